// File: rtl/pf_ram_ctrl.sv
// pf_ram_ctrl: port-A sequencer for the four-lane playfield RAM.
// It shares RAM port A between CPU accesses and a hardware fill engine.
// Every RAM drive signal comes straight from a flop.
// Read data passes through the RAM's combinational lane mux, which follows ram_ce_n.

module pf_ram_ctrl #(
  parameter int FILL_STARVE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_ack,
  input  logic       fill_start,
  input  logic [7:0] fill_val,
  input  logic [3:0] fill_lanes,
  output logic       fill_busy,
  output logic       fill_done,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_din,
  output logic [3:0] ram_ce_n,
  output logic [3:0] ram_we_n,
  input  logic [7:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU_WR,
    S_CPU_RD1,
    S_CPU_RD2,
    S_FILL,
    S_ACK
  } state_t;

  localparam logic [7:0] STARVE_MAX = 8'(FILL_STARVE);

  state_t     state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic [7:0] fill_cnt_q, fill_cnt_d;
  logic [7:0] fill_val_q, fill_val_d;
  logic [3:0] fill_lanes_q, fill_lanes_d;
  logic       fill_busy_q, fill_busy_d;
  logic       fill_done_q, fill_done_d;
  logic [7:0] cpu_dout_q, cpu_dout_d;
  logic [7:0] ram_addr_q, ram_addr_d;
  logic [7:0] ram_din_q, ram_din_d;
  logic [3:0] ram_ce_n_q, ram_ce_n_d;
  logic [3:0] ram_we_n_q, ram_we_n_d;

  logic       fill_last;
  logic       fill_pending;
  logic       starved;
  logic       cpu_grant;
  logic       fill_grant;
  logic [3:0] cpu_lane;

  // The address-255 slot is the one now on the bus, so the fill ends at this edge.
  // A fill_start in the same cycle blocks a fill grant.
  // That stops a stale slot being issued with the old value or address.
  assign fill_last    = (state_q == S_FILL) && (ram_addr_q == 8'hFF);
  assign fill_pending = fill_busy_q && !fill_last && !fill_start;
  assign starved      = fill_pending && (starve_q == STARVE_MAX);
  assign cpu_lane     = 4'b0001 << cpu_addr[9:8];

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and arbitration.
  // CPU wins unless the pending fill has been starved too long.
  // ACK always returns to IDLE, so a request still held during ACK is not taken again.
  always_comb begin
    state_d    = state_q;
    cpu_grant  = 1'b0;
    fill_grant = 1'b0;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (cpu_req && !starved) begin
          cpu_grant = 1'b1;
          state_d   = cpu_we ? S_CPU_WR : S_CPU_RD1;
        end else if (fill_pending) begin
          fill_grant = 1'b1;
          state_d    = S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CPU_WR:  state_d = S_ACK;
      S_CPU_RD1: state_d = S_CPU_RD2;
      S_CPU_RD2: state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // RAM drive for the state being entered, so the strobes are registered.
  // RD2 holds the read drive so the lane mux stays on the read lane.
  always_comb begin
    ram_addr_d = 8'h00;
    ram_din_d  = 8'h00;
    ram_ce_n_d = 4'hF;
    ram_we_n_d = 4'hF;
    case (state_d)
      S_CPU_WR: begin
        ram_addr_d = cpu_addr[7:0];
        ram_din_d  = cpu_din;
        ram_ce_n_d = ~cpu_lane;
        ram_we_n_d = ~cpu_lane;
      end
      S_CPU_RD1: begin
        ram_addr_d = cpu_addr[7:0];
        ram_ce_n_d = ~cpu_lane;
      end
      S_CPU_RD2: begin
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_ce_n_d = ram_ce_n_q;
        ram_we_n_d = ram_we_n_q;
      end
      S_FILL: begin
        ram_addr_d = fill_cnt_q;
        ram_din_d  = fill_val_q;
        ram_ce_n_d = ~fill_lanes_q;
        ram_we_n_d = ~fill_lanes_q;
      end
      default: ;
    endcase
  end

  // Fill engine, starve counter and read-data capture.
  // A restart overrides completion, and an empty mask completes at once.
  always_comb begin
    fill_cnt_d   = fill_cnt_q;
    fill_val_d   = fill_val_q;
    fill_lanes_d = fill_lanes_q;
    fill_busy_d  = fill_busy_q;
    fill_done_d  = 1'b0;
    starve_d     = starve_q;
    cpu_dout_d   = cpu_dout_q;

    if (fill_grant) fill_cnt_d = fill_cnt_q + 8'd1;

    if (fill_last) begin
      fill_busy_d = 1'b0;
      fill_done_d = 1'b1;
    end

    if (fill_start) begin
      fill_val_d   = fill_val;
      fill_lanes_d = fill_lanes;
      fill_cnt_d   = 8'h00;
      if (fill_lanes == 4'h0) begin
        fill_busy_d = 1'b0;
        fill_done_d = 1'b1;
      end else begin
        fill_busy_d = 1'b1;
        fill_done_d = 1'b0;
      end
    end

    if (fill_grant) begin
      starve_d = 8'h00;
    end else if (cpu_grant && fill_pending && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 8'd1;
    end

    if (state_q == S_CPU_RD2) cpu_dout_d = ram_dout;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q     <= 8'h00;
      fill_cnt_q   <= 8'h00;
      fill_val_q   <= 8'h00;
      fill_lanes_q <= 4'h0;
      fill_busy_q  <= 1'b0;
      fill_done_q  <= 1'b0;
      cpu_dout_q   <= 8'h00;
      ram_addr_q   <= 8'h00;
      ram_din_q    <= 8'h00;
      ram_ce_n_q   <= 4'hF;
      ram_we_n_q   <= 4'hF;
    end else begin
      starve_q     <= starve_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_val_q   <= fill_val_d;
      fill_lanes_q <= fill_lanes_d;
      fill_busy_q  <= fill_busy_d;
      fill_done_q  <= fill_done_d;
      cpu_dout_q   <= cpu_dout_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_ce_n_q   <= ram_ce_n_d;
      ram_we_n_q   <= ram_we_n_d;
    end
  end

  assign cpu_ack   = (state_q == S_ACK);
  assign cpu_dout  = cpu_dout_q;
  assign fill_busy = fill_busy_q;
  assign fill_done = fill_done_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_ce_n  = ram_ce_n_q;
  assign ram_we_n  = ram_we_n_q;

endmodule

// File: tb/tb_pf_ram_ctrl.sv
// tb_pf_ram_ctrl: directed bench for pf_ram_ctrl.
// It uses a behavioural four-lane playfield RAM model.

module tb_pf_ram_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cpu_ack;
  logic       fill_start;
  logic [7:0] fill_val;
  logic [3:0] fill_lanes;
  logic       fill_busy;
  logic       fill_done;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic [3:0] ram_ce_n;
  logic [3:0] ram_we_n;
  logic [7:0] ram_dout;

  logic       memClear;
  logic [7:0] mem [4][256];
  logic [7:0] shadow [4][256];
  logic [7:0] rdQ [4];

  int nCompared   = 0;
  int nMismatched = 0;

  int         ackCycle;
  logic [7:0] ackDout;
  logic [3:0] ceLog [12];
  logic [3:0] weLog [12];
  logic [7:0] addrLog [12];
  logic [7:0] dinLog [12];

  pf_ram_ctrl #(.FILL_STARVE(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_ack   (cpu_ack),
    .fill_start(fill_start),
    .fill_val  (fill_val),
    .fill_lanes(fill_lanes),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_ce_n  (ram_ce_n),
    .ram_we_n  (ram_we_n),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model: per-lane synchronous write and read, active-low strobes
  always @(posedge clk) begin
    if (memClear) begin
      for (int l = 0; l < 4; l++)
        for (int a = 0; a < 256; a++) mem[l][a] <= 8'h00;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (!ram_ce_n[l]) begin
          if (!ram_we_n[l]) mem[l][ram_addr] <= ram_din;
          rdQ[l] <= mem[l][ram_addr];
        end
      end
    end
  end

  // Combinational lane mux on the enabled lane
  always_comb begin
    ram_dout = 8'h00;
    for (int l = 3; l >= 0; l--)
      if (!ram_ce_n[l]) ram_dout = rdQ[l];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [9:0] addr, input logic [7:0] din);
    ackCycle = 0;
    ackDout  = 8'h00;
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = addr;
    cpu_din  = din;
    for (int c = 1; c <= 10 && ackCycle == 0; c++) begin
      @(negedge clk);
      ceLog[c]   = ram_ce_n;
      weLog[c]   = ram_we_n;
      addrLog[c] = ram_addr;
      dinLog[c]  = ram_din;
      if (cpu_ack) begin
        ackCycle = c;
        ackDout  = cpu_dout;
        cpu_req  = 1'b0;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic pulseFill(input logic [7:0] val, input logic [3:0] lanes);
    fill_start = 1'b1;
    fill_val   = val;
    fill_lanes = lanes;
    @(negedge clk);
    fill_start = 1'b0;
  endtask

  function automatic int countLaneMismatch(input logic [3:0] lanes, input logic [7:0] val);
    int bad = 0;
    for (int l = 0; l < 4; l++)
      if (lanes[l])
        for (int a = 0; a < 256; a++)
          if (mem[l][a] !== val) bad++;
    return bad;
  endfunction

  initial begin
    int writes, dones, firstWrite, doneCycle, badMask, badAddr, badDin;
    int grants, acks, fills, sinceFill, badPattern, bad, firstAddr;
    logic prevRd, curRd, finished, found, doneSeen;

    reset = 1'b1; memClear = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'h000; cpu_din = 8'h00;
    fill_start = 1'b0; fill_val = 8'h00; fill_lanes = 4'h0;
    repeat (2) @(negedge clk);
    memClear = 1'b0;

    // Reset values
    checkOutput("rst_cpu_dout", 32'(cpu_dout), 32'h00);
    checkOutput("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    checkOutput("rst_fill_busy", 32'(fill_busy), 32'h0);
    checkOutput("rst_fill_done", 32'(fill_done), 32'h0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'h00);
    checkOutput("rst_ram_din", 32'(ram_din), 32'h00);
    checkOutput("rst_ram_ce_n", 32'(ram_ce_n), 32'hF);
    checkOutput("rst_ram_we_n", 32'(ram_we_n), 32'hF);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Empty mask: done next cycle, no busy, no writes
    pulseFill(8'h99, 4'h0);
    checkOutput("empty_done", 32'(fill_done), 32'h1);
    checkOutput("empty_busy", 32'(fill_busy), 32'h0);
    checkOutput("empty_we_n", 32'(ram_we_n), 32'hF);
    @(negedge clk);
    checkOutput("empty_done_once", 32'(fill_done), 32'h0);
    checkOutput("empty_busy_later", 32'(fill_busy), 32'h0);

    // Uncontested fill 5C on lanes 0 and 2
    pulseFill(8'h5C, 4'h5);
    checkOutput("fill_busy_rise", 32'(fill_busy), 32'h1);
    checkOutput("fill_first_idle", 32'(ram_we_n), 32'hF);
    writes = 0; dones = 0; firstWrite = 0; doneCycle = 0;
    badMask = 0; badAddr = 0; badDin = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (ram_we_n != 4'hF) begin
        if (firstWrite == 0) firstWrite = c;
        if (ram_we_n != 4'hA || ram_ce_n != 4'hA) badMask++;
        if (ram_addr != 8'(writes)) badAddr++;
        if (ram_din != 8'h5C) badDin++;
        writes++;
      end
      if (fill_done) begin
        dones++;
        doneCycle = c;
      end
    end
    checkOutput("fill_writes", writes, 256);
    checkOutput("fill_first_write", firstWrite, 1);
    checkOutput("fill_done_cycle", doneCycle, 257);
    checkOutput("fill_done_count", dones, 1);
    checkOutput("fill_mask", badMask, 0);
    checkOutput("fill_addr_seq", badAddr, 0);
    checkOutput("fill_din", badDin, 0);
    checkOutput("fill_busy_fall", 32'(fill_busy), 32'h0);
    checkOutput("fill_lanes02", countLaneMismatch(4'h5, 8'h5C), 0);
    checkOutput("fill_lanes13", countLaneMismatch(4'hA, 8'h00), 0);

    // CPU write 3C to lane 2 addr 7F, then read it back
    applyStimulus(1'b1, {2'd2, 8'h7F}, 8'h3C);
    checkOutput("wr_ack_cycle", ackCycle, 2);
    checkOutput("wr_ce_n", 32'(ceLog[1]), 32'hB);
    checkOutput("wr_we_n", 32'(weLog[1]), 32'hB);
    checkOutput("wr_addr", 32'(addrLog[1]), 32'h7F);
    checkOutput("wr_din", 32'(dinLog[1]), 32'h3C);
    checkOutput("wr_we_n_one_cycle", 32'(weLog[2]), 32'hF);
    checkOutput("wr_mem", 32'(mem[2][8'h7F]), 32'h3C);
    @(negedge clk);
    applyStimulus(1'b0, {2'd2, 8'h7F}, 8'h00);
    checkOutput("rd_ack_cycle", ackCycle, 3);
    checkOutput("rd1_ce_n", 32'(ceLog[1]), 32'hB);
    checkOutput("rd1_we_n", 32'(weLog[1]), 32'hF);
    checkOutput("rd1_addr", 32'(addrLog[1]), 32'h7F);
    checkOutput("rd2_ce_n", 32'(ceLog[2]), 32'hB);
    checkOutput("rd2_we_n", 32'(weLog[2]), 32'hF);
    checkOutput("rd_dout", 32'(ackDout), 32'h3C);
    @(negedge clk);

    // Saturating CPU reads during a fill of 77 on all lanes
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {2'd1, 8'h10};
    grants = 0; acks = 0; fills = 0; sinceFill = 0; badPattern = 0; dones = 0;
    prevRd = 1'b0; finished = 1'b0; doneSeen = 1'b0;
    for (int c = 1; c <= 6000 && !finished; c++) begin
      @(negedge clk);
      fill_start = (c == 3);
      fill_val   = 8'h77;
      fill_lanes = 4'hF;
      curRd = (ram_ce_n != 4'hF) && (ram_we_n == 4'hF);
      if (curRd && !prevRd) begin
        grants++;
        sinceFill++;
      end
      prevRd = curRd;
      if (ram_we_n == 4'h0) begin
        fills++;
        if (fills > 1 && sinceFill != 3) badPattern++;
        sinceFill = 0;
      end
      if (fill_done) begin
        dones++;
        doneSeen = 1'b1;
      end
      if (cpu_ack) begin
        acks++;
        if (doneSeen) begin
          cpu_req  = 1'b0;
          finished = 1'b1;
        end
      end
    end
    fill_start = 1'b0;
    cpu_req = 1'b0;
    checkOutput("sat_finished", 32'(finished), 32'h1);
    checkOutput("sat_fill_writes", fills, 256);
    checkOutput("sat_pattern", badPattern, 0);
    checkOutput("sat_done_count", dones, 1);
    checkOutput("sat_all_acked", acks, grants);
    checkOutput("sat_mem", countLaneMismatch(4'hF, 8'h77), 0);
    repeat (2) @(negedge clk);

    // Restart at address 0x90 with value 11
    pulseFill(8'h22, 4'hF);
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (ram_we_n == 4'h0 && ram_addr == 8'h90) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("rst_fill_found90", 32'(found), 32'h1);
    pulseFill(8'h11, 4'hF);
    checkOutput("restart_busy", 32'(fill_busy), 32'h1);
    checkOutput("restart_no_done", 32'(fill_done), 32'h0);
    writes = 0; dones = 0; firstAddr = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ram_we_n == 4'h0) begin
        if (firstAddr < 0) firstAddr = int'(ram_addr);
        writes++;
      end
      if (fill_done) dones++;
    end
    checkOutput("restart_first_addr", firstAddr, 0);
    checkOutput("restart_writes", writes, 256);
    checkOutput("restart_done_count", dones, 1);
    checkOutput("restart_mem", countLaneMismatch(4'hF, 8'h11), 0);

    // Restart coinciding with the final fill slot
    pulseFill(8'h33, 4'h1);
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (ram_we_n == 4'hE && ram_addr == 8'hFF) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("last_found_ff", 32'(found), 32'h1);
    pulseFill(8'h44, 4'h1);
    checkOutput("last_done_suppressed", 32'(fill_done), 32'h0);
    checkOutput("last_busy_kept", 32'(fill_busy), 32'h1);
    writes = 0; dones = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ram_we_n == 4'hE) writes++;
      if (fill_done) dones++;
    end
    checkOutput("last_writes", writes, 256);
    checkOutput("last_done_count", dones, 1);
    checkOutput("last_mem", countLaneMismatch(4'h1, 8'h44), 0);

    // Asynchronous reset at fill address 0x40
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 256; a++) shadow[l][a] = mem[l][a];
    pulseFill(8'hAA, 4'hF);
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (ram_we_n == 4'h0 && ram_addr == 8'h40) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("arst_found40", 32'(found), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("arst_ce_n", 32'(ram_ce_n), 32'hF);
    checkOutput("arst_we_n", 32'(ram_we_n), 32'hF);
    checkOutput("arst_addr", 32'(ram_addr), 32'h00);
    checkOutput("arst_din", 32'(ram_din), 32'h00);
    checkOutput("arst_busy", 32'(fill_busy), 32'h0);
    checkOutput("arst_done", 32'(fill_done), 32'h0);
    checkOutput("arst_ack", 32'(cpu_ack), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    writes = 0; dones = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ram_we_n != 4'hF) writes++;
      if (fill_done) dones++;
    end
    checkOutput("arst_no_writes", writes, 0);
    checkOutput("arst_no_done", dones, 0);
    bad = 0;
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 256; a++)
        if (mem[l][a] !== ((a < 8'h40) ? 8'hAA : shadow[l][a])) bad++;
    checkOutput("arst_mem", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
